// File: rtl/pad_gpio_pkg.sv
// Shared definitions for the GPIO pad bank.
// Holds the default IO buffer attributes, the synchroniser depth floor and the
// glitch-filter counter width helper used by every pad channel.
package pad_gpio_pkg;

    localparam int unsigned DRIVE_DEFAULT      = 8;
    localparam string       IOSTANDARD_DEFAULT = "LVCMOS33";
    localparam int unsigned SYNC_STAGES_MIN    = 2;

    // Counter must hold values 0..filt_len.
    function automatic int unsigned filt_cnt_width(input int unsigned filt_len);
        return $clog2(filt_len + 1);
    endfunction

endpackage

// File: rtl/pad_gpio_bank_if.sv
// Peripheral-side bundle of the GPIO pad bank.
//   out_data / out_en / od_mode : per-bit drive value, enable, open-drain select
//   filt_en                     : per-bit glitch filter enable
//   in_data / in_rise / in_fall : synchronised input and one-cycle edge pulses
// master = GPIO peripheral, slave = pad bank.
interface pad_gpio_bank_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_en;
    logic [WIDTH-1:0] od_mode;
    logic [WIDTH-1:0] filt_en;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_rise;
    logic [WIDTH-1:0] in_fall;

    modport master (
        output out_data, out_en, od_mode, filt_en,
        input  in_data, in_rise, in_fall
    );

    modport slave (
        input  out_data, out_en, od_mode, filt_en,
        output in_data, in_rise, in_fall
    );
endinterface

// File: rtl/pad_gpio_chan.sv
// One bidirectional GPIO pad bit.
// Ports:
//   HCLK, HRESETn           : clock, synchronous active-low reset
//   pad_io                  : FPGA pin
//   out_data_i/out_en_i     : drive value / enable (registered, 1 cycle to pin)
//   od_mode_i               : 1 = open-drain, 0 = push-pull
//   filt_en_i               : glitch filter enable
//   in_data_o               : synchronised, optionally filtered pin value
//   in_rise_o/in_fall_o     : one-cycle pulses when in_data_o changes
module pad_gpio_chan
    import pad_gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned DRIVE       = DRIVE_DEFAULT,
    parameter string       IOSTANDARD  = IOSTANDARD_DEFAULT
) (
    input  logic HCLK,
    input  logic HRESETn,
    inout  wire  pad_io,
    input  logic out_data_i,
    input  logic out_en_i,
    input  logic od_mode_i,
    input  logic filt_en_i,
    output logic in_data_o,
    output logic in_rise_o,
    output logic in_fall_o
);

    localparam int unsigned         CntW    = filt_cnt_width(FILT_LEN);
    localparam logic [CntW-1:0]     CntLast = CntW'(FILT_LEN - 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("pad_gpio_chan: SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("pad_gpio_chan: FILT_LEN must be at least 1");
    end
    if (DRIVE == 0) begin : g_bad_drive
        $error("pad_gpio_chan: DRIVE must be non-zero");
    end
    if (IOSTANDARD == "") begin : g_bad_iostd
        $error("pad_gpio_chan: IOSTANDARD must be named");
    end

    logic                   out_data_q, out_data_d;
    logic                   out_en_q, out_en_d;
    logic                   od_mode_q, od_mode_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   in_data_q, in_data_d;
    logic                   in_rise_q, in_rise_d;
    logic                   in_fall_q, in_fall_d;

    logic drive_active;
    logic buf_t;
    logic pad_in;
    logic sync_out;
    logic next_in;

    // Open-drain never drives a 1: a high request releases the pin.
    assign drive_active = out_en_q & ~(od_mode_q & out_data_q);
    assign buf_t        = ~drive_active;

    // Generic IO buffer: active-high tristate, input always reads the pin.
    assign pad_io = buf_t ? 1'bz : out_data_q;
    assign pad_in = pad_io;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        out_data_d = out_data_i;
        out_en_d   = out_en_i;
        od_mode_d  = od_mode_i;
        sync_d     = {sync_q[SYNC_STAGES-2:0], pad_in};
        cnt_d      = '0;
        next_in    = in_data_q;

        if (!filt_en_i) begin
            next_in = sync_out;
        end else if (sync_out != in_data_q) begin
            // FILT_LEN consecutive differing cycles are needed to accept a change.
            if (cnt_q == CntLast) begin
                next_in = sync_out;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        in_data_d = next_in;
        in_rise_d = next_in & ~in_data_q;
        in_fall_d = ~next_in & in_data_q;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            out_data_q <= 1'b0;
            out_en_q   <= 1'b0;
            od_mode_q  <= 1'b0;
            sync_q     <= '0;
            cnt_q      <= '0;
            in_data_q  <= 1'b0;
            in_rise_q  <= 1'b0;
            in_fall_q  <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            od_mode_q  <= od_mode_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            in_data_q  <= in_data_d;
            in_rise_q  <= in_rise_d;
            in_fall_q  <= in_fall_d;
        end
    end

    assign in_data_o = in_data_q;
    assign in_rise_o = in_rise_q;
    assign in_fall_o = in_fall_q;

endmodule

// File: rtl/pad_gpio_bank.sv
// Bank of WIDTH registered bidirectional GPIO pads between the GPIO peripheral
// and the FPGA pins. Every bit is an independent pad_gpio_chan.
// Ports:
//   HCLK, HRESETn : clock, synchronous active-low reset
//   PAD           : FPGA pins
//   gpio          : peripheral bundle (slave side), see pad_gpio_bank_if
module pad_gpio_bank
    import pad_gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned DRIVE       = DRIVE_DEFAULT,
    parameter string       IOSTANDARD  = IOSTANDARD_DEFAULT
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    inout  wire [WIDTH-1:0]  PAD,
    pad_gpio_bank_if.slave   gpio
);

    if (WIDTH < 1) begin : g_bad_width
        $error("pad_gpio_bank: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
        pad_gpio_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .DRIVE       (DRIVE),
            .IOSTANDARD  (IOSTANDARD)
        ) u_chan (
            .HCLK       (HCLK),
            .HRESETn    (HRESETn),
            .pad_io     (PAD[i]),
            .out_data_i (gpio.out_data[i]),
            .out_en_i   (gpio.out_en[i]),
            .od_mode_i  (gpio.od_mode[i]),
            .filt_en_i  (gpio.filt_en[i]),
            .in_data_o  (gpio.in_data[i]),
            .in_rise_o  (gpio.in_rise[i]),
            .in_fall_o  (gpio.in_fall[i])
        );
    end

endmodule

// File: tb/tb_pad_gpio_bank.sv
// Bench for pad_gpio_bank: directed scenarios with literal expectations, then
// randomized traffic, all compared each cycle against a behavioural model.
module tb_pad_gpio_bank;
    import pad_gpio_pkg::*;

    localparam int unsigned W    = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned FL   = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    wire  [W-1:0] pad;
    logic [W-1:0] ext_oe  = '0;
    logic [W-1:0] ext_val = '0;

    int n_checks = 0;
    int n_errors = 0;

    pad_gpio_bank_if #(.WIDTH(W)) gpio ();

    // Board pull-ups plus an external driver per pin.
    for (genvar i = 0; i < int'(W); i++) begin : g_pin
        pullup (pad[i]);
        assign pad[i] = ext_oe[i] ? ext_val[i] : 1'bz;
    end

    pad_gpio_bank #(
        .WIDTH       (W),
        .SYNC_STAGES (SYNC),
        .FILT_LEN    (FL),
        .DRIVE       (8),
        .IOSTANDARD  ("LVCMOS33")
    ) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .PAD     (pad),
        .gpio    (gpio)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_odat, m_oen, m_od;
    logic [W-1:0] m_in, m_rise, m_fall;
    int           m_run [W];
    logic [W-1:0] m_hist [$];   // last SYNC pin samples, oldest first
    bit           m_valid = 1'b0;

    // Pin level from the registered drive request, else external driver, else pull-up.
    function automatic logic [W-1:0] model_pad();
        logic [W-1:0] p;
        for (int i = 0; i < int'(W); i++) begin
            if (m_oen[i] && (!m_od[i] || !m_odat[i])) p[i] = m_odat[i];
            else if (ext_oe[i])                       p[i] = ext_val[i];
            else                                      p[i] = 1'b1;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] pad_now;
        logic [W-1:0] s;
        logic [W-1:0] nxt;
        pad_now = model_pad();
        if (!rst_n) begin
            m_odat = '0; m_oen = '0; m_od = '0;
            m_in = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < int'(W); i++) m_run[i] = 0;
            m_hist.delete();
            for (int k = 0; k < int'(SYNC); k++) m_hist.push_back('0);
        end else begin
            s   = m_hist[0];
            nxt = m_in;
            for (int i = 0; i < int'(W); i++) begin
                if (!gpio.filt_en[i]) begin
                    nxt[i]   = s[i];
                    m_run[i] = 0;
                end else if (s[i] != m_in[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(FL)) begin
                        nxt[i]   = s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rise = nxt & ~m_in;
            m_fall = ~nxt & m_in;
            m_in   = nxt;
            void'(m_hist.pop_front());
            m_hist.push_back(pad_now);
            m_odat = gpio.out_data;
            m_oen  = gpio.out_en;
            m_od   = gpio.od_mode;
        end
        m_valid = 1'b1;
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("pad", pad, model_pad());
            check("in_data", gpio.in_data, m_in);
            check("in_rise", gpio.in_rise, m_rise);
            check("in_fall", gpio.in_fall, m_fall);
            check("rise_fall_overlap", gpio.in_rise & gpio.in_fall, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic nv;
        int   rises;

        gpio.out_data = '0;
        gpio.out_en   = '1;
        gpio.od_mode  = '0;
        gpio.filt_en  = '0;

        // Reset: drive requested but pins must float to the pull-ups.
        repeat (3) step();
        check("reset_pad_z", pad, 8'hFF);
        check("reset_in_data", gpio.in_data, 8'h00);
        check("reset_rise", gpio.in_rise, 8'h00);
        check("reset_fall", gpio.in_fall, 8'h00);

        // Push-pull / open-drain mix.
        gpio.out_data = 8'hA5;
        gpio.od_mode  = 8'h0F;
        rst_n = 1'b1;
        step();
        check("pp_od_pad", pad, 8'hA5);
        step(); step();
        check("loopback_pullup_seen", gpio.in_data, 8'hFF);
        check("loopback_rise", gpio.in_rise, 8'hFF);
        step();
        check("loopback_in_data", gpio.in_data, 8'hA5);
        check("loopback_fall", gpio.in_fall, 8'h5A);

        // Hand the pins to the external driver, filters on.
        gpio.out_en = '0;
        step(); step();
        ext_val = '0;
        ext_oe  = '1;
        gpio.filt_en = '1;
        repeat (10) step();
        check("settle", gpio.in_data, 8'h00);

        // 3-cycle glitch on bit 3 is rejected.
        ext_val[3] = 1'b1;
        repeat (3) step();
        ext_val[3] = 1'b0;
        rises = 0;
        repeat (10) begin
            step();
            rises += int'(gpio.in_rise[3]);
        end
        check_bit("glitch_in_data", gpio.in_data[3], 1'b0);
        check_bit("glitch_no_rise", rises == 0, 1'b1);

        // 4-cycle pulse on bit 3 passes, SYNC+4 edges after the pin rises.
        ext_val[3] = 1'b1;
        repeat (4) step();
        ext_val[3] = 1'b0;
        step();
        check_bit("pulse4_early", gpio.in_data[3], 1'b0);
        step();
        check_bit("pulse4_in_data", gpio.in_data[3], 1'b1);
        check_bit("pulse4_rise", gpio.in_rise[3], 1'b1);
        step();
        check_bit("pulse4_rise_one_cycle", gpio.in_rise[3], 1'b0);
        repeat (8) step();

        // Unfiltered toggling on bit 0.
        gpio.filt_en = '0;
        step(); step();
        for (int k = 0; k < 4; k++) begin
            nv = ~ext_val[0];
            ext_val[0] = nv;
            step(); step();
            check_bit("unfilt_before", gpio.in_data[0], ~nv);
            step();
            check_bit("unfilt_after", gpio.in_data[0], nv);
            check_bit("unfilt_rise", gpio.in_rise[0], nv);
            check_bit("unfilt_fall", gpio.in_fall[0], ~nv);
            step();
            check_bit("unfilt_pulse_end", gpio.in_rise[0] | gpio.in_fall[0], 1'b0);
            step();
        end
        ext_val[0] = 1'b0;
        gpio.filt_en = '1;
        repeat (8) step();

        // filt_en dropped mid-count on bit 2: fresh count afterwards.
        ext_val[2] = 1'b1;
        step(); step();
        ext_val[2] = 1'b0;
        step(); step();
        gpio.filt_en[2] = 1'b0;
        step();
        check_bit("filt_drop_hold", gpio.in_data[2], 1'b0);
        gpio.filt_en[2] = 1'b1;
        ext_val[2] = 1'b1;
        repeat (5) step();
        check_bit("filt_reenable_early", gpio.in_data[2], 1'b0);
        step();
        check_bit("filt_reenable_update", gpio.in_data[2], 1'b1);
        ext_val[2] = 1'b0;
        repeat (8) step();

        // Reset in the middle of a count on bit 3.
        ext_val[3] = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("midreset_in_data", gpio.in_data, 8'h00);
        check("midreset_no_fall", gpio.in_fall, 8'h00);
        rst_n = 1'b1;
        repeat (5) step();
        check_bit("midreset_early", gpio.in_data[3], 1'b0);
        step();
        check_bit("midreset_update", gpio.in_data[3], 1'b1);
        check_bit("midreset_rise", gpio.in_rise[3], 1'b1);
        ext_val[3] = 1'b0;
        repeat (8) step();

        // Randomized traffic: external pins only on bits not requested for drive.
        for (int ph = 0; ph < 40; ph++) begin
            ext_oe = '0;
            step();
            gpio.out_en  = W'($urandom);
            gpio.od_mode = W'($urandom);
            step(); step();
            ext_oe = ~gpio.out_en;
            repeat (60) begin
                gpio.out_data = W'($urandom);
                ext_val = ext_val ^ W'($urandom & $urandom & $urandom);
                if ($urandom_range(0, 15) == 0) gpio.filt_en = W'($urandom);
                rst_n = ($urandom_range(0, 299) != 0);
                step();
            end
            rst_n = 1'b1;
        end
        ext_oe = '0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
